// File: rtl/mem_port_sequencer_pkg.sv
// Shared types for the memory port sequencer: FSM states, requester IDs and
// MemLength codes.
package mem_port_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam logic LEN_BYTE = 1'b0;
    localparam logic LEN_WORD = 1'b1;

    // Bit 1 of the one-hot grant is the data path, bit 0 the fetch path.
    function automatic req_id_e gnt_to_id(input logic [1:0] gnt_onehot);
        req_id_e id;
        if (gnt_onehot[1]) begin
            id = REQ_D;
        end else begin
            id = REQ_F;
        end
        return id;
    endfunction

endpackage

// File: rtl/mem_port_sequencer_if.sv
// Requester and memory-side signal bundle of the memory port sequencer.
// master = sequencer side, slave = requesters plus memory.
interface mem_port_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              F_Req;
    logic [ADDR_W-1:0] F_Addr;
    logic              F_Gnt;
    logic              F_Done;

    logic              D_Req;
    logic              D_Wr;
    logic              D_Len;
    logic [ADDR_W-1:0] D_Addr;
    logic [DATA_W-1:0] D_WrData;
    logic              D_Gnt;
    logic              D_Done;

    logic [DATA_W-1:0] RdData;
    logic              Err;

    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemEnable;
    logic              MemLength;
    logic              MemRd;
    logic              MemWr;
    logic              MemRdy;
    logic              Busy;

    modport master (
        input  F_Req, F_Addr, D_Req, D_Wr, D_Len, D_Addr, D_WrData, MemRData, MemRdy,
        output F_Gnt, F_Done, D_Gnt, D_Done, RdData, Err,
               MemAddr, MemWData, MemEnable, MemLength, MemRd, MemWr, Busy
    );

    modport slave (
        output F_Req, F_Addr, D_Req, D_Wr, D_Len, D_Addr, D_WrData, MemRData, MemRdy,
        input  F_Gnt, F_Done, D_Gnt, D_Done, RdData, Err,
               MemAddr, MemWData, MemEnable, MemLength, MemRd, MemWr, Busy
    );

endinterface

// File: rtl/mem_port_sequencer_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, on a tie the side that
// was not served last wins.
module rr_arb2
    import mem_port_sequencer_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last,
    output logic [1:0] gnt_onehot
);

    // One-hot grant selection from the request pair and last owner
    always_comb begin
        gnt_onehot = 2'b00;
        case (req)
            2'b01:   gnt_onehot = 2'b01;
            2'b10:   gnt_onehot = 2'b10;
            2'b11:   gnt_onehot = (last == REQ_F) ? 2'b10 : 2'b01;
            default: gnt_onehot = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Arbitrates the fetch and data paths onto the single memory port and runs the
// SETUP / STROBE / WAIT / DONE handshake with a WAIT-state timeout.
module mem_port_sequencer
    import mem_port_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STROBE_CYC = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    mem_port_sequencer_if.master bus
);

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);

    seq_state_e        state_r,   state_nxt_s;
    req_id_e           owner_r,   owner_nxt_s;
    req_id_e           last_r,    last_nxt_s;
    logic              wr_r,      wr_nxt_s;
    logic              len_r,     len_nxt_s;
    logic [ADDR_W-1:0] addr_r,    addr_nxt_s;
    logic [DATA_W-1:0] wdata_r,   wdata_nxt_s;
    logic [DATA_W-1:0] rd_data_r, rd_data_nxt_s;
    logic              err_r,     err_nxt_s;
    logic [3:0]        strobe_cnt_r;
    logic [7:0]        wait_cnt_r;
    logic [1:0]        gnt_onehot_s;

    logic in_xfer_s;
    logic mem_en_r,  mem_en_nxt_s;
    logic mem_rd_r,  mem_rd_nxt_s;
    logic mem_wr_r,  mem_wr_nxt_s;
    logic f_gnt_r,   f_gnt_nxt_s;
    logic d_gnt_r,   d_gnt_nxt_s;
    logic f_done_r,  f_done_nxt_s;
    logic d_done_r,  d_done_nxt_s;
    logic busy_r,    busy_nxt_s;

    rr_arb2 u_arb (
        .req        ({bus.D_Req, bus.F_Req}),
        .last       (last_r),
        .gnt_onehot (gnt_onehot_s)
    );

    // Next state, transfer latches and completion status
    always_comb begin
        state_nxt_s   = state_r;
        owner_nxt_s   = owner_r;
        last_nxt_s    = last_r;
        wr_nxt_s      = wr_r;
        len_nxt_s     = len_r;
        addr_nxt_s    = addr_r;
        wdata_nxt_s   = wdata_r;
        rd_data_nxt_s = rd_data_r;
        err_nxt_s     = err_r;
        case (state_r)
            ST_IDLE: begin
                err_nxt_s = 1'b0;
                if (gnt_onehot_s != 2'b00) begin
                    state_nxt_s = ST_SETUP;
                    owner_nxt_s = gnt_to_id(gnt_onehot_s);
                    if (gnt_to_id(gnt_onehot_s) == REQ_D) begin
                        wr_nxt_s    = bus.D_Wr;
                        len_nxt_s   = bus.D_Len;
                        addr_nxt_s  = bus.D_Addr;
                        wdata_nxt_s = bus.D_Wr ? bus.D_WrData : {DATA_W{1'b0}};
                    end else begin
                        wr_nxt_s    = 1'b0;
                        len_nxt_s   = LEN_WORD;
                        addr_nxt_s  = bus.F_Addr;
                        wdata_nxt_s = {DATA_W{1'b0}};
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_STROBE;
            end
            ST_STROBE: begin
                if (strobe_cnt_r == STROBE_LAST) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_STROBE;
                end
            end
            ST_WAIT: begin
                // A ready on the final WAIT cycle still counts as success
                if (bus.MemRdy) begin
                    state_nxt_s = ST_DONE;
                    err_nxt_s   = 1'b0;
                    if (!wr_r) begin
                        rd_data_nxt_s = bus.MemRData;
                    end else begin
                        rd_data_nxt_s = rd_data_r;
                    end
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s   = ST_DONE;
                    err_nxt_s     = 1'b1;
                    rd_data_nxt_s = {DATA_W{1'b0}};
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                last_nxt_s  = owner_r;
                err_nxt_s   = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        in_xfer_s    = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_STROBE) ||
                       (state_nxt_s == ST_WAIT);
        mem_en_nxt_s = in_xfer_s;
        mem_rd_nxt_s = (state_nxt_s == ST_STROBE) && !wr_nxt_s;
        mem_wr_nxt_s = (state_nxt_s == ST_STROBE) && wr_nxt_s;
        f_gnt_nxt_s  = in_xfer_s && (owner_nxt_s == REQ_F);
        d_gnt_nxt_s  = in_xfer_s && (owner_nxt_s == REQ_D);
        f_done_nxt_s = (state_nxt_s == ST_DONE) && (owner_nxt_s == REQ_F);
        d_done_nxt_s = (state_nxt_s == ST_DONE) && (owner_nxt_s == REQ_D);
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
    end

    // State, latches and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            owner_r   <= REQ_F;
            last_r    <= REQ_F;
            wr_r      <= 1'b0;
            len_r     <= LEN_BYTE;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            rd_data_r <= {DATA_W{1'b0}};
            err_r     <= 1'b0;
            mem_en_r  <= 1'b0;
            mem_rd_r  <= 1'b0;
            mem_wr_r  <= 1'b0;
            f_gnt_r   <= 1'b0;
            d_gnt_r   <= 1'b0;
            f_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            owner_r   <= owner_nxt_s;
            last_r    <= last_nxt_s;
            wr_r      <= wr_nxt_s;
            len_r     <= len_nxt_s;
            addr_r    <= addr_nxt_s;
            wdata_r   <= wdata_nxt_s;
            rd_data_r <= rd_data_nxt_s;
            err_r     <= err_nxt_s;
            mem_en_r  <= mem_en_nxt_s;
            mem_rd_r  <= mem_rd_nxt_s;
            mem_wr_r  <= mem_wr_nxt_s;
            f_gnt_r   <= f_gnt_nxt_s;
            d_gnt_r   <= d_gnt_nxt_s;
            f_done_r  <= f_done_nxt_s;
            d_done_r  <= d_done_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Strobe and WAIT cycle counters restart on every entry to their state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            strobe_cnt_r <= 4'd0;
            wait_cnt_r   <= 8'd0;
        end else begin
            if (state_r == ST_STROBE) begin
                strobe_cnt_r <= strobe_cnt_r + 4'd1;
            end else begin
                strobe_cnt_r <= 4'd0;
            end
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
        end
    end

    assign bus.MemEnable = mem_en_r;
    assign bus.MemRd     = mem_rd_r;
    assign bus.MemWr     = mem_wr_r;
    assign bus.MemAddr   = addr_r;
    assign bus.MemWData  = wdata_r;
    assign bus.MemLength = len_r;
    assign bus.F_Gnt     = f_gnt_r;
    assign bus.D_Gnt     = d_gnt_r;
    assign bus.F_Done    = f_done_r;
    assign bus.D_Done    = d_done_r;
    assign bus.RdData    = rd_data_r;
    assign bus.Err       = err_r;
    assign bus.Busy      = busy_r;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: expected completions are queued when a
// request is issued and compared when the matching Done pulse appears.
module tb_mem_port_sequencer;
    import mem_port_sequencer_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STROBE_CYC = 2;
    localparam int TIMEOUT    = 16;

    localparam int RDY_ALWAYS = 0;
    localparam int RDY_IN_WAIT = 1;
    localparam int RDY_NEVER  = 2;
    localparam int RDY_SETUP  = 3;

    typedef struct {
        logic        side;
        logic        wr;
        logic        len;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] rd_exp;
    } xfer_t;

    logic  Clk = 1'b0;
    logic  Reset;
    xfer_t sb[$];
    logic [31:0] model_rd;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    mem_port_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STROBE_CYC (STROBE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_xfer(input logic side, input logic wr, input logic len,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic tmo);
        xfer_t x;
        x.side  = side;
        x.wr    = wr;
        x.len   = len;
        x.err   = tmo;
        x.addr  = addr;
        x.wdata = wr ? wdata : 32'h0;
        x.rdata = rdata;
        if (tmo) model_rd = 32'h0;
        else if (!wr) model_rd = rdata;
        x.rd_exp = model_rd;
        sb.push_back(x);
    endtask

    // Runs the memory side for the transfer at the head of the scoreboard
    task automatic wait_done(input int rdy_mode, input bit keep_req,
                             output int cyc, output int rd_cyc, output int wr_cyc);
        xfer_t exp;
        bit got;
        bit strobe_seen;
        cyc = 0; rd_cyc = 0; wr_cyc = 0; got = 1'b0; strobe_seen = 1'b0;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        exp = sb[0];
        bus.MemRdy = (rdy_mode == RDY_ALWAYS);
        while (!got && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            bus.MemRData = exp.wr ? 32'hBAD0_0BAD : exp.rdata;
            if (bus.MemRd || bus.MemWr) begin
                strobe_seen = 1'b1;
                rd_cyc += int'(bus.MemRd);
                wr_cyc += int'(bus.MemWr);
                check("strobe_addr", 64'(bus.MemAddr), 64'(exp.addr));
                check("strobe_wdata", 64'(bus.MemWData), 64'(exp.wdata));
                check("strobe_len", 64'(bus.MemLength), 64'(exp.len));
                check("strobe_gnt", 64'({bus.D_Gnt, bus.F_Gnt}), exp.side ? 64'd2 : 64'd1);
            end
            case (rdy_mode)
                RDY_IN_WAIT: bus.MemRdy = strobe_seen && bus.MemEnable && !bus.MemRd && !bus.MemWr;
                RDY_SETUP:   bus.MemRdy = bus.MemEnable && !strobe_seen;
                default:     ;
            endcase
            if (bus.F_Done || bus.D_Done) begin
                got = 1'b1;
                void'(sb.pop_front());
                check("done_side", 64'({bus.D_Done, bus.F_Done}), exp.side ? 64'd2 : 64'd1);
                check("rd_data", 64'(bus.RdData), 64'(exp.rd_exp));
                check("err", 64'(bus.Err), 64'(exp.err));
                check("gnt_low_in_done", 64'({bus.D_Gnt, bus.F_Gnt, bus.MemEnable}), 64'd0);
                if (!keep_req) begin
                    if (exp.side) bus.D_Req = 1'b0;
                    else bus.F_Req = 1'b0;
                end
            end
        end
        check("done_seen", 64'(got), 64'd1);
        bus.MemRdy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rd_cyc, wr_cyc;
        bit done_any;
        model_rd     = 32'h0;
        Reset        = 1'b1;
        bus.F_Req    = 1'b0;
        bus.F_Addr   = 32'h0;
        bus.D_Req    = 1'b0;
        bus.D_Wr     = 1'b0;
        bus.D_Len    = 1'b0;
        bus.D_Addr   = 32'h0;
        bus.D_WrData = 32'h0;
        bus.MemRData = 32'h0;
        bus.MemRdy   = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_mem_ctl", 64'({bus.MemEnable, bus.MemRd, bus.MemWr, bus.MemLength}), 64'd0);
        check("rst_req_side", 64'({bus.F_Gnt, bus.D_Gnt, bus.F_Done, bus.D_Done, bus.Busy, bus.Err}), 64'd0);
        check("rst_rd_data", 64'(bus.RdData), 64'd0);
        check("rst_mem_bus", {bus.MemAddr, bus.MemWData}, 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Tie after reset: D first, then strict alternation while both held
        bus.F_Addr = 32'h104;
        bus.D_Addr = 32'h200;
        bus.D_Wr   = 1'b0;
        bus.D_Len  = LEN_WORD;
        push_xfer(REQ_D, 1'b0, LEN_WORD, 32'h200, 32'h0, 32'h1111_2222, 1'b0);
        push_xfer(REQ_F, 1'b0, LEN_WORD, 32'h104, 32'h0, 32'h3333_4444, 1'b0);
        push_xfer(REQ_D, 1'b0, LEN_WORD, 32'h200, 32'h0, 32'h5555_6666, 1'b0);
        push_xfer(REQ_F, 1'b0, LEN_WORD, 32'h104, 32'h0, 32'h7777_8888, 1'b0);
        bus.F_Req = 1'b1;
        bus.D_Req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(RDY_ALWAYS, (i < 3), cyc, rd_cyc, wr_cyc);
            check("rr_latency", 64'(cyc), (i == 0) ? 64'd5 : 64'd6);
            check("rr_rd_cycles", 64'(rd_cyc), 64'd2);
        end
        bus.D_Req = 1'b0;
        repeat (2) @(negedge Clk);
        check("rr_idle_busy", 64'(bus.Busy), 64'd0);

        // Fetch read, ready one cycle into WAIT
        bus.F_Addr = 32'h100;
        push_xfer(REQ_F, 1'b0, LEN_WORD, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
        bus.F_Req = 1'b1;
        wait_done(RDY_IN_WAIT, 1'b0, cyc, rd_cyc, wr_cyc);
        check("f_latency", 64'(cyc), 64'd5);
        check("f_rd_cycles", 64'(rd_cyc), 64'd2);
        check("f_wr_cycles", 64'(wr_cyc), 64'd0);
        repeat (2) @(negedge Clk);

        // Byte store leaves RdData alone
        bus.D_Wr     = 1'b1;
        bus.D_Len    = LEN_BYTE;
        bus.D_Addr   = 32'h23;
        bus.D_WrData = 32'h5A;
        push_xfer(REQ_D, 1'b1, LEN_BYTE, 32'h23, 32'h5A, 32'h0, 1'b0);
        bus.D_Req = 1'b1;
        wait_done(RDY_ALWAYS, 1'b0, cyc, rd_cyc, wr_cyc);
        check("st_wr_cycles", 64'(wr_cyc), 64'd2);
        check("st_rd_cycles", 64'(rd_cyc), 64'd0);
        check("st_latency", 64'(cyc), 64'd5);
        repeat (2) @(negedge Clk);

        // MemRdy never rises: timeout after TIMEOUT WAIT cycles
        bus.D_Wr   = 1'b0;
        bus.D_Len  = LEN_WORD;
        bus.D_Addr = 32'h480;
        push_xfer(REQ_D, 1'b0, LEN_WORD, 32'h480, 32'h0, 32'hCAFE_F00D, 1'b1);
        bus.D_Req = 1'b1;
        wait_done(RDY_NEVER, 1'b0, cyc, rd_cyc, wr_cyc);
        check("tmo_latency", 64'(cyc), 64'(3 + STROBE_CYC + TIMEOUT - 1));
        check("tmo_busy_in_done", 64'(bus.Busy), 64'd1);
        @(negedge Clk);
        check("tmo_busy_after", 64'({bus.Busy, bus.Err}), 64'd0);
        @(negedge Clk);

        // MemRdy pulse during SETUP only is ignored
        bus.F_Addr = 32'h140;
        push_xfer(REQ_F, 1'b0, LEN_WORD, 32'h140, 32'h0, 32'h1234_5678, 1'b1);
        bus.F_Req = 1'b1;
        wait_done(RDY_SETUP, 1'b0, cyc, rd_cyc, wr_cyc);
        check("setup_rdy_latency", 64'(cyc), 64'(3 + STROBE_CYC + TIMEOUT - 1));
        repeat (2) @(negedge Clk);

        // Reset in the middle of STROBE
        bus.F_Addr = 32'h300;
        bus.F_Req  = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("mid_strobe_rd", 64'({bus.MemRd, bus.MemEnable, bus.F_Gnt}), 64'd7);
        #1;
        Reset     = 1'b1;
        bus.F_Req = 1'b0;
        #1;
        check("rst_drop", 64'({bus.MemRd, bus.MemEnable, bus.F_Gnt, bus.Busy}), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        done_any = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            done_any = done_any | bus.F_Done | bus.D_Done;
        end
        check("rst_no_done", 64'(done_any), 64'd0);
        model_rd = 32'h0;
        bus.F_Addr = 32'h304;
        push_xfer(REQ_F, 1'b0, LEN_WORD, 32'h304, 32'h0, 32'h0BAD_F00D, 1'b0);
        bus.F_Req = 1'b1;
        wait_done(RDY_ALWAYS, 1'b0, cyc, rd_cyc, wr_cyc);
        check("post_rst_latency", 64'(cyc), 64'd5);
        repeat (2) @(negedge Clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
